// File: rtl/video_stream_pkg.sv
// Shared types and constants for the video stream packer.
package video_stream_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  typedef logic [31:0] axis_word_t;

  localparam int unsigned WORDS_PER_4PIX = 3;
  localparam int unsigned PIX_PER_GROUP  = 4;

  // Output words needed to carry one line of 24-bit pixels.
  function automatic int unsigned words_per_line(input int unsigned x_pixels);
    return (x_pixels * WORDS_PER_4PIX) / PIX_PER_GROUP;
  endfunction

endpackage

// File: rtl/video_frame_counter.sv
// Word/line position tracker. The counters hold the index of the next word
// to be loaded into the output register, so the flags describe that word.
module video_frame_counter #(
  parameter int unsigned X_WORDS = 192,
  parameter int unsigned Y_LINES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic advance_i,
  input  logic restart_i,
  output logic is_first_o,
  output logic is_last_in_line_o,
  output logic is_last_in_frame_o
);

  localparam int unsigned XW = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
  localparam int unsigned YW = (Y_LINES > 1) ? $clog2(Y_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_WORDS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_LINES - 1);

  logic [XW-1:0] x_word_q, x_word_d;
  logic [YW-1:0] y_line_q, y_line_d;

  // Next position: restart wins over advance; both counters wrap at their last value.
  always_comb begin
    x_word_d = x_word_q;
    y_line_d = y_line_q;
    if (restart_i) begin
      x_word_d = '0;
      y_line_d = '0;
    end else if (advance_i) begin
      if (x_word_q == X_LAST) begin
        x_word_d = '0;
        y_line_d = (y_line_q == Y_LAST) ? '0 : y_line_q + YW'(1);
      end else begin
        x_word_d = x_word_q + XW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_word_q <= '0;
      y_line_q <= '0;
    end else begin
      x_word_q <= x_word_d;
      y_line_q <= y_line_d;
    end
  end

  assign is_first_o         = (x_word_q == '0) && (y_line_q == '0);
  assign is_last_in_line_o  = (x_word_q == X_LAST);
  assign is_last_in_frame_o = (x_word_q == X_LAST) && (y_line_q == Y_LAST);

endmodule

// File: rtl/video_stream_packer.sv
// Packs 24-bit RGB pixels, four at a time, into three 32-bit AXI4-Stream
// video words with start-of-frame (tuser) and end-of-line (tlast) marking.
module video_stream_packer #(
  parameter int unsigned X_PIXELS = 256,
  parameter int unsigned Y_LINES  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_pixel,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        frame_done,
  output logic        sof_error
);

  import video_stream_pkg::*;

  localparam int unsigned X_WORDS = words_per_line(X_PIXELS);

  rgb_pixel_t pix;
  logic [1:0]  phase_q, phase_d, eff_phase;
  logic [23:0] residue_q, residue_d;
  axis_word_t  tdata_q, tdata_d, word;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        frame_last_q, frame_last_d;
  logic        frame_done_q, frame_done_d;
  logic        sof_error_q, sof_error_d;
  logic        accept, out_hs, sof_bad, load;
  logic        is_first, is_last_in_line, is_last_in_frame;

  assign pix      = rgb_pixel_t'(in_pixel);
  assign in_ready = !rst && (!tvalid_q || out_stream_tready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = tvalid_q && out_stream_tready;
  assign sof_bad  = accept && in_sof && !((phase_q == 2'd0) && is_first);

  video_frame_counter #(
    .X_WORDS (X_WORDS),
    .Y_LINES (Y_LINES)
  ) u_frame_counter (
    .clk                (clk),
    .rst                (rst),
    .advance_i          (load),
    .restart_i          (sof_bad),
    .is_first_o         (is_first),
    .is_last_in_line_o  (is_last_in_line),
    .is_last_in_frame_o (is_last_in_frame)
  );

  // Packing datapath and output register next-state.
  always_comb begin
    phase_d      = phase_q;
    residue_d    = residue_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    frame_last_d = frame_last_q;
    load         = 1'b0;
    word         = '0;
    eff_phase    = sof_bad ? 2'd0 : phase_q;
    frame_done_d = out_hs && frame_last_q;
    sof_error_d  = sof_bad;

    if (out_hs) begin
      tvalid_d = 1'b0;
    end

    if (accept) begin
      phase_d = eff_phase + 2'd1;
      case (eff_phase)
        2'd0: begin
          residue_d = pix;
        end
        2'd1: begin
          word      = {pix.b, residue_q};
          residue_d = {8'h00, pix.r, pix.g};
          load      = 1'b1;
        end
        2'd2: begin
          word      = {pix.g, pix.b, residue_q[15:0]};
          residue_d = {16'h0000, pix.r};
          load      = 1'b1;
        end
        2'd3: begin
          word      = {pix, residue_q[7:0]};
          residue_d = '0;
          load      = 1'b1;
        end
      endcase
    end

    if (load) begin
      tdata_d      = word;
      tvalid_d     = 1'b1;
      tuser_d      = is_first;
      tlast_d      = is_last_in_line;
      frame_last_d = is_last_in_frame;
    end
  end

  // State and output registers; reset drops any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      residue_q    <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      frame_last_q <= 1'b0;
      frame_done_q <= 1'b0;
      sof_error_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      residue_q    <= residue_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      frame_last_q <= frame_last_d;
      frame_done_q <= frame_done_d;
      sof_error_q  <= sof_error_d;
    end
  end

  assign out_stream_tdata  = tdata_q;
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tvalid = tvalid_q;
  assign frame_done        = frame_done_q;
  assign sof_error         = sof_error_q;

endmodule
